// File: rtl/ifu_fetch_if.sv
// Instruction-memory fetch channel: request/grant address phase, then rvalid data phase.
interface ifu_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, fetches one word at a time, computes the next PC on
// completion, and locks into a sticky fault state on a misaligned jump-register target.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  ifu_fetch_if.master        imem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               exec_done,
  input  logic [1:0]         NPCOp,
  input  logic [25:0]        imm26,
  input  logic [31:0]        ra,
  output logic [31:0]        instr_count,
  output logic               fault
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StErr} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] count_q;
  logic [31:0] npc;
  logic [31:0] br_off;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{imm26[15]}}, imm26[15:0], 2'b00};

  always_comb begin
    npc = pc_plus4;
    unique case (NPCOp)
      2'b00: npc = pc_plus4;
      2'b01: npc = pc_plus4 + br_off;
      2'b10: npc = {pc_plus4[31:28], imm26, 2'b00};
      2'b11: npc = ra;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        StReq: begin
          if (imem.gnt) state_q <= StWait;
        end
        StWait: begin
          if (imem.rvalid) begin
            instr_q <= imem.rdata;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (exec_done) begin
            // The faulting target is still loaded so software can see where it went.
            pc_q    <= npc;
            count_q <= count_q + 32'd1;
            state_q <= (npc[1:0] != 2'b00) ? StErr : StReq;
          end
        end
        StErr: begin
          state_q <= StErr;
        end
      endcase
    end
  end

  // Handshake and status outputs depend only on registered state.
  assign imem.req    = (state_q == StReq);
  assign imem.addr   = pc_q;
  assign instr_valid = (state_q == StHold);
  assign fault       = (state_q == StErr);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: table of fetch/complete vectors plus reset and stray-event cases.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exec_done;
  logic [1:0]  NPCOp;
  logic [25:0] imm26;
  logic [31:0] ra;
  logic [31:0] instr_count;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;

  ifu_fetch_if imem_bus ();

  ifu_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .exec_done   (exec_done),
    .NPCOp       (NPCOp),
    .imm26       (imm26),
    .ra          (ra),
    .instr_count (instr_count),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cur_pc;
    logic [31:0] rdata;
    int          gnt_delay;
    bit          stray;
    logic [1:0]  op;
    logic [25:0] imm;
    logic [31:0] ra_val;
    logic [31:0] exp_npc;
    bit          exp_fault;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = 32'hDEAD_BEEF;
    exec_done       = 1'b0;
    NPCOp           = 2'b00;
    imm26           = '0;
    ra              = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Fetch from exp_addr with gnt held off gnt_delay cycles; optional stray rvalid/exec_done.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data, input int gnt_delay,
                       input bit stray, input logic [31:0] exp_count);
    check("req_in_req", {31'b0, imem_bus.req}, 32'd1);
    check("addr_in_req", imem_bus.addr, exp_addr);
    for (int i = 0; i < gnt_delay; i++) begin
      imem_bus.rvalid = stray;
      imem_bus.rdata  = 32'hBAD0_0000;
      tick();
      imem_bus.rvalid = 1'b0;
      check("req_held", {31'b0, imem_bus.req}, 32'd1);
      check("addr_stable", imem_bus.addr, exp_addr);
      check("no_valid_in_req", {31'b0, instr_valid}, 32'd0);
    end
    imem_bus.gnt = 1'b1;
    tick();
    imem_bus.gnt = 1'b0;
    check("req_low_in_wait", {31'b0, imem_bus.req}, 32'd0);
    if (stray) begin
      exec_done = 1'b1;
      NPCOp     = 2'b11;
      ra        = 32'h0000_0002;
      tick();
      exec_done = 1'b0;
      check("wait_ignores_done_req", {31'b0, imem_bus.req}, 32'd0);
      check("wait_ignores_done_valid", {31'b0, instr_valid}, 32'd0);
      check("wait_ignores_done_count", instr_count, exp_count);
      check("wait_ignores_done_fault", {31'b0, fault}, 32'd0);
    end
    imem_bus.rvalid = 1'b1;
    imem_bus.rdata  = data;
    tick();
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = 32'hDEAD_BEEF;
    check("instr_valid", {31'b0, instr_valid}, 32'd1);
    check("instr", instr, data);
    check("pc", pc, exp_addr);
    check("pc_plus4", pc_plus4, exp_addr + 32'd4);
  endtask

  task automatic complete(input logic [1:0] op, input logic [25:0] imm, input logic [31:0] rv);
    exec_done = 1'b1;
    NPCOp     = op;
    imm26     = imm;
    ra        = rv;
    tick();
    idle_inputs();
  endtask

  initial begin
    //           cur_pc        rdata         dly stray op     imm26           ra             npc           flt
    vecs[0]  = '{32'h0000_0000, 32'h2008_0005, 0, 0, 2'b00, 26'h0,          32'h0,         32'h0000_0004, 0};
    vecs[1]  = '{32'h0000_0004, 32'h0000_0001, 0, 0, 2'b00, 26'h0,          32'h0,         32'h0000_0008, 0};
    vecs[2]  = '{32'h0000_0008, 32'h0000_0002, 5, 1, 2'b00, 26'h0,          32'h0,         32'h0000_000C, 0};
    vecs[3]  = '{32'h0000_000C, 32'h0000_0003, 1, 0, 2'b00, 26'h0,          32'h0,         32'h0000_0010, 0};
    vecs[4]  = '{32'h0000_0010, 32'h1000_FFFC, 0, 0, 2'b01, 26'h000_FFFC,   32'h0,         32'h0000_0004, 0};
    vecs[5]  = '{32'h0000_0004, 32'h0000_0005, 0, 0, 2'b11, 26'h0,          32'h0000_0010, 32'h0000_0010, 0};
    vecs[6]  = '{32'h0000_0010, 32'h1000_0003, 2, 0, 2'b01, 26'h3FF_0003,   32'h0,         32'h0000_0020, 0};
    vecs[7]  = '{32'h0000_0020, 32'h0000_0007, 0, 0, 2'b11, 26'h0,          32'h3000_0000, 32'h3000_0000, 0};
    vecs[8]  = '{32'h3000_0000, 32'h0800_0040, 0, 0, 2'b10, 26'h000_0040,   32'h0,         32'h3000_0100, 0};
    vecs[9]  = '{32'h3000_0100, 32'h0000_0009, 0, 0, 2'b11, 26'h0,          32'h0000_0104, 32'h0000_0104, 0};
    vecs[10] = '{32'h0000_0104, 32'h0000_000A, 0, 0, 2'b11, 26'h0,          32'hFFFF_FFFC, 32'hFFFF_FFFC, 0};
    vecs[11] = '{32'hFFFF_FFFC, 32'h0000_000B, 0, 0, 2'b00, 26'h0,          32'h0,         32'h0000_0000, 0};
    vecs[12] = '{32'h0000_0000, 32'h0000_000C, 0, 0, 2'b11, 26'h0,          32'h0000_0102, 32'h0000_0102, 1};

    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    check("rst_req", {31'b0, imem_bus.req}, 32'd1);
    check("rst_addr", imem_bus.addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      fetch(vecs[i].cur_pc, vecs[i].rdata, vecs[i].gnt_delay, vecs[i].stray, 32'(i));
      // One extra HOLD cycle without exec_done must keep the instruction waiting.
      tick();
      check("hold_valid", {31'b0, instr_valid}, 32'd1);
      check("hold_count", instr_count, 32'(i));
      complete(vecs[i].op, vecs[i].imm, vecs[i].ra_val);
      check("npc", pc, vecs[i].exp_npc);
      check("next_addr", imem_bus.addr, vecs[i].exp_npc);
      check("next_req", {31'b0, imem_bus.req}, {31'b0, !vecs[i].exp_fault});
      check("next_fault", {31'b0, fault}, {31'b0, vecs[i].exp_fault});
      check("next_valid", {31'b0, instr_valid}, 32'd0);
      check("count", instr_count, 32'(i + 1));
    end

    // In ERR, every handshake and completion input is ignored.
    for (int i = 0; i < 3; i++) begin
      exec_done       = 1'b1;
      imem_bus.gnt    = 1'b1;
      imem_bus.rvalid = 1'b1;
      tick();
      check("err_fault", {31'b0, fault}, 32'd1);
      check("err_req", {31'b0, imem_bus.req}, 32'd0);
      check("err_valid", {31'b0, instr_valid}, 32'd0);
      check("err_pc", pc, 32'h0000_0102);
      check("err_count", instr_count, 32'd13);
    end

    do_reset();
    check("err_rst_fault", {31'b0, fault}, 32'd0);
    check("err_rst_req", {31'b0, imem_bus.req}, 32'd1);
    check("err_rst_addr", imem_bus.addr, 32'h0);
    check("err_rst_count", instr_count, 32'd0);
    check("err_rst_instr", instr, 32'h0);

    // Complete one instruction, then reset in the middle of the next fetch's WAIT.
    fetch(32'h0, 32'h2008_0005, 0, 0, 32'd0);
    complete(2'b00, 26'h0, 32'h0);
    check("pre_rst_count", instr_count, 32'd1);
    imem_bus.gnt = 1'b1;
    tick();
    imem_bus.gnt = 1'b0;
    check("mid_wait_req", {31'b0, imem_bus.req}, 32'd0);
    rst             = 1'b1;
    imem_bus.rvalid = 1'b1;
    exec_done       = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    check("wait_rst_req", {31'b0, imem_bus.req}, 32'd1);
    check("wait_rst_addr", imem_bus.addr, 32'h0);
    check("wait_rst_count", instr_count, 32'd0);
    check("wait_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("wait_rst_instr", instr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
